// File: rtl/rr_arb_16_idx_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_16_idx_pkg
//   Shared constants and types for the 16-requester round-robin arbiter.
//   NUM_REQ / IDX_W : requester count and grant-index width.
//   state_t         : arbiter state encoding (IDLE / GRANT).
//   DEF_TIMEOUT     : default maximum grant hold time in cycles.
// ----------------------------------------------------------------------------
package rr_arb_16_idx_pkg;

    localparam int NUM_REQ     = 16;
    localparam int IDX_W       = 4;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage : rr_arb_16_idx_pkg

// File: rtl/rr_pick_16.sv
// ----------------------------------------------------------------------------
// rr_pick_16
//   Combinational round-robin pick: scans req starting at bit 'start',
//   wrapping modulo 16, and returns the first set bit.
//   Ports:
//     req   [15:0] in  : request vector
//     start [3:0]  in  : first bit position to examine
//     idx   [3:0]  out : index of the first set bit at/after start (wrapping)
//     any          out : at least one request bit is set
// ----------------------------------------------------------------------------
module rr_pick_16
    import rr_arb_16_idx_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;

    // Doubling the vector turns the wrap-around rotate into a plain slice:
    // w_rot[0] is req[start], w_rot[1] is req[start+1], ...
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[start +: NUM_REQ];

    // Lowest set bit of the rotated vector is the first requester after start.
    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDX_W'(i);
        end
    end

    assign any = |req;
    assign idx = w_off + start;   // 4-bit add wraps back to an absolute index

endmodule : rr_pick_16

// File: rtl/rr_arb_16_idx.sv
// ----------------------------------------------------------------------------
// rr_arb_16_idx
//   16-requester round-robin arbiter with a registered grant index and valid.
//   A grant is held until the owner asserts done, drops its request, or the
//   hold counter reaches TIMEOUT cycles. On release the search restarts just
//   after the old owner, so another pending requester is granted on the same
//   edge (no idle bubble) and the old owner has lowest priority.
//   Parameters:
//     TIMEOUT : max cycles a grant is held (0 disables the timeout)
//     CNT_W   : hold counter width, 2**CNT_W must exceed TIMEOUT
//   Ports:
//     clk           in  : rising-edge clock
//     rst_n         in  : asynchronous active-low reset
//     req   [15:0]  in  : request vector
//     done          in  : owner releases the grant (ignored while idle)
//     gnt_idx [3:0] out : index of current owner (holds last value when idle)
//     gnt_valid     out : grant active
//     timeout_pulse out : one-cycle pulse after a timeout-only release
// ----------------------------------------------------------------------------
module rr_arb_16_idx
    import rr_arb_16_idx_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout_pulse
);

    // Counter value on the last allowed grant cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             r_state;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_to_pulse;

    logic [IDX_W-1:0]   w_after_owner;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic               w_owner_req;
    logic               w_to_hit;
    logic               w_release;

    assign w_after_owner = r_gnt_idx + 1'b1;
    assign w_owner_req   = req[r_gnt_idx];
    assign w_to_hit      = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_release     = (r_state == ST_GRANT) && (done || !w_owner_req || w_to_hit);

    // Idle searches from the rotation pointer; a release searches from just
    // past the current owner. Both collapse onto one picker.
    assign w_start = (r_state == ST_GRANT) ? w_after_owner : r_ptr;

    rr_pick_16 u_pick (
        .req   (req),
        .start (w_start),
        .idx   (w_pick),
        .any   (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_to_pulse <= 1'b0;
        end else begin
            r_to_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_GRANT;
                        r_gnt_idx <= w_pick;
                        r_cnt     <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_ptr      <= w_after_owner;
                        r_cnt      <= '0;
                        // Pulse only when the timeout alone forced the release.
                        r_to_pulse <= w_to_hit && !done && w_owner_req;
                        if (w_any) r_gnt_idx <= w_pick;
                        else       r_state   <= ST_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_idx       = r_gnt_idx;
    assign gnt_valid     = (r_state == ST_GRANT);
    assign timeout_pulse = r_to_pulse;

endmodule : rr_arb_16_idx

// File: tb/tb_rr_arb_16_idx.sv
// ----------------------------------------------------------------------------
// tb_rr_arb_16_idx
//   Self-checking bench: directed scenarios plus randomized req/done traffic,
//   every cycle compared against a behavioural arbiter model.
// ----------------------------------------------------------------------------
module tb_rr_arb_16_idx;

    localparam int TO = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req   = '0;
    logic        done  = 1'b0;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout_pulse;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_age;
    bit m_pulse;

    always #5 clk = ~clk;

    rr_arb_16_idx #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .gnt_idx       (gnt_idx),
        .gnt_valid     (gnt_valid),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First requester found walking upward from 'start', wrapping at 16.
    function automatic void m_pick(input logic [15:0] r, input int start,
                                   output bit any, output int idx);
        any = 1'b0;
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            if (!any && r[(start + k) % 16]) begin
                any = 1'b1;
                idx = (start + k) % 16;
            end
        end
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(gnt_valid),     32'(m_valid));
        chk({tag, ".idx"},   32'(gnt_idx),       32'(m_idx));
        chk({tag, ".pulse"}, 32'(timeout_pulse), 32'(m_pulse));
    endtask

    // Advance one clock with the currently driven inputs; update model; check.
    task automatic step(input string tag);
        bit nv, npl, any, to, rel;
        int ni, np, na, pk;
        nv = m_valid; ni = m_idx; np = m_ptr; na = m_age + 1; npl = 1'b0;
        if (!m_valid) begin
            m_pick(req, m_ptr, any, pk);
            if (any) begin nv = 1'b1; ni = pk; na = 0; end
        end else begin
            to  = (TO != 0) && (m_age == TO - 1);
            rel = done || !req[m_idx] || to;
            if (rel) begin
                np  = (m_idx + 1) % 16;
                na  = 0;
                npl = to && !done && req[m_idx];
                m_pick(req, np, any, pk);
                if (any) ni = pk; else nv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_idx = ni; m_ptr = np; m_age = na; m_pulse = npl;
        check_out(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        #1;
        m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_age = 0; m_pulse = 1'b0;
        check_out("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seq [5];
        seq[0] = 4'd0; seq[1] = 4'd8; seq[2] = 4'd15; seq[3] = 4'd0; seq[4] = 4'd8;

        @(posedge clk);
        #1;

        // Single requester, done releases, pointer advances to 1
        do_reset();
        req = 16'h0001;
        step("single.grant");
        chk("single.grant.const", 32'({gnt_valid, gnt_idx}), 32'h10);
        done = 1'b1; req = 16'h0000;
        step("single.done");
        chk("single.done.const", 32'(gnt_valid), 32'h0);
        done = 1'b0; req = 16'hFFFF;
        step("single.ptr1");
        chk("single.ptr1.const", 32'(gnt_idx), 32'h1);

        // Rotation with wrap 15 -> 0, no gaps
        do_reset();
        req = 16'h8101; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rot");
            chk("rot.seq", 32'({gnt_valid, gnt_idx}), 32'({1'b1, seq[i]}));
        end
        done = 1'b0;

        // Timeout-only release, sole requester re-granted
        do_reset();
        req = 16'h0010;
        for (int i = 0; i < 4; i++) step("to.hold");
        step("to.fire");
        chk("to.fire.const", 32'({timeout_pulse, gnt_valid, gnt_idx}), 32'h34);
        step("to.after");
        chk("to.after.const", 32'(timeout_pulse), 32'h0);

        // Owner drops request, hand-off without bubble
        do_reset();
        req = 16'h0008;
        step("drop.grant");
        req = 16'h0028;
        step("drop.hold");
        req = 16'h0020;
        step("drop.handoff");
        chk("drop.handoff.const", 32'({timeout_pulse, gnt_valid, gnt_idx}), 32'h15);

        // Async reset mid-grant, pointer back to 0
        do_reset();
        req = 16'h0200;
        step("arst.grant");
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_age = 0; m_pulse = 1'b0;
        check_out("arst.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1; req = 16'hFFFF;
        step("arst.regrant");
        chk("arst.regrant.const", 32'(gnt_idx), 32'h0);

        // done while idle is ignored; done coincident with timeout -> no pulse
        do_reset();
        req = 16'h0000; done = 1'b1;
        step("idle.done1");
        step("idle.done2");
        done = 1'b0; req = 16'h0010;
        for (int i = 0; i < 4; i++) step("coin.hold");
        done = 1'b1;
        step("coin.fire");
        chk("coin.fire.const", 32'(timeout_pulse), 32'h0);
        done = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'h0000;
                    1: req = 16'($urandom);
                    2: req = 16'($urandom & $urandom & $urandom);
                    default: req = req ^ (16'h1 << $urandom_range(0, 15));
                endcase
            end
            done = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_rr_arb_16_idx
